hist_stream_analyzer: RTL
=========================

HIST_STREAM_ANALYZER -- requirements
Module: hist_stream_analyzer

Interface
REQ-001 The block SHALL have a parameter BIN_W, default 16, giving the bin index width in bits.
REQ-002 The block SHALL have a parameter CNT_W, default 8, giving the per-bin count width in bits.
REQ-003 The block SHALL have a parameter TOT_W, default 24, giving the running total width in bits.
REQ-004 The block SHALL have these ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  CNT_W  count of the current bin in the histogram readout stream.
- valid_in  input  1  data_in holds a valid bin count this cycle.
- last_in  input  1  current beat is the final bin of the frame; qualified by valid_in.
- peak_bin  output  BIN_W  index of the bin with the largest count in the last completed frame.
- peak_count  output  CNT_W  count of that bin.
- total  output  TOT_W  saturating sum of all counts in the last completed frame.
- nonzero_bins  output  BIN_W  number of bins with count > 0 in the last completed frame.
- num_bins  output  BIN_W  number of beats in the last completed frame, minus 1.
- frame_count  output  8  completed frames since reset; wraps.
- result_valid  output  1  one-cycle pulse when the result outputs update.
- overrun  output  1  sticky flag: a frame exceeded 2^BIN_W beats.
- busy  output  1  a frame is in progress.

Function
REQ-005 The block SHALL always accept the stream: every cycle with valid_in=1 is one beat, and there is no backpressure.
REQ-006 The FSM SHALL have two states, IDLE and ACCUM, and busy SHALL be 1 exactly when the FSM is in ACCUM.
REQ-007 In IDLE, a beat with last_in=0 SHALL start a frame: it is bin 0, it initialises the working registers from this beat, and the FSM moves to ACCUM.
REQ-008 In IDLE, a beat with last_in=1 SHALL be a complete one-bin frame: the FSM stays in IDLE and the results are published.
REQ-009 In ACCUM, each beat SHALL increment the working bin index by 1 and update the working registers.
REQ-010 In ACCUM, a beat with last_in=1 SHALL publish the results and return the FSM to IDLE.
REQ-011 The working registers SHALL update per beat as follows:
- working total = working total + data_in, saturating at 2^TOT_W-1.
- nonzero count increments when data_in != 0.
- The peak updates only when data_in > working peak_count (strict), so on a tie the lowest bin index is kept.
REQ-012 Bin 0 SHALL always initialise the peak to (index 0, data_in), including when data_in=0.
REQ-013 When a frame ends, the final beat SHALL be included in the results, and result_valid SHALL pulse in the cycle after that beat.
REQ-014 peak_bin, peak_count, total, nonzero_bins and num_bins SHALL update in that same cycle and SHALL hold until the next frame completes.
REQ-015 frame_count SHALL increment in the cycle result_valid pulses, wrapping from 255 to 0.
REQ-016 A new frame's first beat MAY arrive in the cycle immediately after a last beat; back-to-back frames SHALL lose no beat.
REQ-017 When last_in=1 and valid_in=0, last_in SHALL be ignored.
REQ-018 Cycles with valid_in=0 in ACCUM SHALL leave all state unchanged; gaps of any length are allowed.
REQ-019 If a beat arrives when the working bin index is 2^BIN_W-1 and last_in=0:
- overrun SHALL set.
- The index SHALL saturate and not wrap.
- Counts SHALL continue to accumulate, with peak updates attributed to index 2^BIN_W-1.
- The frame SHALL continue until last_in.
REQ-020 overrun SHALL clear only on reset.
REQ-021 total SHALL saturate at 2^TOT_W-1 and SHALL NOT wrap.
REQ-022 nonzero_bins SHALL saturate at 2^BIN_W-1.

Reset
REQ-023 While reset=1 at a clock edge, the FSM SHALL go to IDLE and all outputs and working registers SHALL clear to 0, so that result_valid=0, busy=0 and overrun=0.
REQ-024 A reset asserted mid-frame SHALL discard the partial frame without publishing and without pulsing result_valid.
REQ-025 The first beat after reset deasserts SHALL be treated as bin 0.
REQ-026 Inputs SHALL be ignored in any cycle where reset=1.

Verification
REQ-027 Frame 4 beats, counts 3,7,7,2, last on the 4th beat -> one cycle later: result_valid=1 for exactly 1 cycle, peak_bin=1, peak_count=7, total=19, nonzero_bins=4, num_bins=3, frame_count=1.
REQ-028 Single beat valid_in=1, last_in=1, count 0 -> next cycle: result_valid=1, peak_bin=0, peak_count=0, total=0, nonzero_bins=0, num_bins=0, busy stays 0 throughout.
REQ-029 Back-to-back frames (5,0,last) then (9,last) on consecutive cycles with no gap -> two result_valid pulses; the 2nd gives peak_count=9, total=9, num_bins=0, frame_count=2.
REQ-030 Frame 1,2,... with valid_in gaps of 3 idle cycles between beats and last_in=1 held while valid_in=0 -> results match the gap-free run, with no early completion.
REQ-031 Reset pulse after 2 beats of a frame, then frame 4,last -> no result_valid for the aborted frame; next result peak_count=4, total=4, frame_count=1.
REQ-032 BIN_W=3, 10 beats of count 255, last on the 10th -> overrun=1, peak_bin=0, total=2550, num_bins=7, overrun stays 1 until reset.

Source files
------------

// File: rtl/hist_stream_analyzer.sv
// Streaming histogram analyzer: per frame, finds the peak bin, the saturating total,
// the number of non-empty bins and the frame length, and publishes them on the last beat.
module hist_stream_analyzer #(
    parameter int BIN_W = 16,
    parameter int CNT_W = 8,
    parameter int TOT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] data_in,
    input  logic             valid_in,
    input  logic             last_in,
    output logic [BIN_W-1:0] peak_bin,
    output logic [CNT_W-1:0] peak_count,
    output logic [TOT_W-1:0] total,
    output logic [BIN_W-1:0] nonzero_bins,
    output logic [BIN_W-1:0] num_bins,
    output logic [7:0]       frame_count,
    output logic             result_valid,
    output logic             overrun,
    output logic             busy
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ACCUM = 1'b1;

    localparam logic [BIN_W-1:0] BIN_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    logic             r_state;
    logic [BIN_W-1:0] r_idx;
    logic [TOT_W-1:0] r_tot;
    logic [BIN_W-1:0] r_nz;
    logic [BIN_W-1:0] r_pk_bin;
    logic [CNT_W-1:0] r_pk_cnt;

    logic [BIN_W-1:0] r_o_pk_bin;
    logic [CNT_W-1:0] r_o_pk_cnt;
    logic [TOT_W-1:0] r_o_tot;
    logic [BIN_W-1:0] r_o_nz;
    logic [BIN_W-1:0] r_o_nb;
    logic [7:0]       r_fc;
    logic             r_rvalid;
    logic             r_overrun;

    logic             w_first;
    logic             w_ovf;
    logic [BIN_W-1:0] w_idx_nx;
    logic [TOT_W-1:0] w_tot_base;
    logic [TOT_W:0]   w_sum;
    logic [TOT_W-1:0] w_tot_nx;
    logic [BIN_W-1:0] w_nz_base;
    logic [BIN_W-1:0] w_nz_nx;
    logic [BIN_W-1:0] w_pk_bin_nx;
    logic [CNT_W-1:0] w_pk_cnt_nx;

    // Next working values assuming the current cycle carries a beat; the first beat of a
    // frame starts from zero so no separate clear is needed between frames.
    always_comb begin
        w_first    = (r_state == ST_IDLE);
        w_ovf      = !w_first && (r_idx == BIN_MAX);
        w_idx_nx   = '0;
        if (!w_first) begin
            w_idx_nx = (r_idx == BIN_MAX) ? BIN_MAX : r_idx + 1'b1;
        end

        w_tot_base = w_first ? '0 : r_tot;
        w_sum      = {1'b0, w_tot_base} + (TOT_W + 1)'(data_in);
        w_tot_nx   = w_sum[TOT_W] ? TOT_MAX : w_sum[TOT_W-1:0];

        w_nz_base  = w_first ? '0 : r_nz;
        w_nz_nx    = w_nz_base;
        if ((data_in != '0) && (w_nz_base != BIN_MAX)) begin
            w_nz_nx = w_nz_base + 1'b1;
        end

        w_pk_bin_nx = r_pk_bin;
        w_pk_cnt_nx = r_pk_cnt;
        if (w_first) begin
            w_pk_bin_nx = '0;
            w_pk_cnt_nx = data_in;
        end else if (data_in > r_pk_cnt) begin
            w_pk_bin_nx = w_idx_nx;
            w_pk_cnt_nx = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_tot      <= '0;
            r_nz       <= '0;
            r_pk_bin   <= '0;
            r_pk_cnt   <= '0;
            r_o_pk_bin <= '0;
            r_o_pk_cnt <= '0;
            r_o_tot    <= '0;
            r_o_nz     <= '0;
            r_o_nb     <= '0;
            r_fc       <= '0;
            r_rvalid   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            if (valid_in) begin
                r_idx    <= w_idx_nx;
                r_tot    <= w_tot_nx;
                r_nz     <= w_nz_nx;
                r_pk_bin <= w_pk_bin_nx;
                r_pk_cnt <= w_pk_cnt_nx;
                if (w_ovf) begin
                    r_overrun <= 1'b1;
                end
                if (last_in) begin
                    r_o_pk_bin <= w_pk_bin_nx;
                    r_o_pk_cnt <= w_pk_cnt_nx;
                    r_o_tot    <= w_tot_nx;
                    r_o_nz     <= w_nz_nx;
                    r_o_nb     <= w_idx_nx;
                    r_fc       <= r_fc + 8'd1;
                    r_rvalid   <= 1'b1;
                    r_state    <= ST_IDLE;
                end else begin
                    r_state <= ST_ACCUM;
                end
            end
        end
    end

    assign peak_bin     = r_o_pk_bin;
    assign peak_count   = r_o_pk_cnt;
    assign total        = r_o_tot;
    assign nonzero_bins = r_o_nz;
    assign num_bins     = r_o_nb;
    assign frame_count  = r_fc;
    assign result_valid = r_rvalid;
    assign overrun      = r_overrun;
    assign busy         = (r_state == ST_ACCUM);

endmodule
